cmd_scheduler: RTL

- Arbitrates command requests from two sources, the debounced-button path and the clap path, into the `logic` datapath.
- Buffers accepted commands in a small FIFO and issues them one at a time as rst/set/state controls.
- Enforces a settle gap after each command so `logic` finishes before the next one arrives.
- Sits between the button/clap controllers and `logic`; its `state_o` also feeds `displayer`.

---
 rtl/cmd_scheduler.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/cmd_scheduler.sv
// cmd_scheduler: arbitrates the button and clap command requesters into a
// small FIFO and issues queued commands one at a time to the `logic`
// datapath as rst/set pulses or a state load, with a settle gap after each.
// Optional feature: define CMD_SCHEDULER_CMD_COUNT_EN to add cmd_cnt_o, a
// wrapping count of issued commands.
module cmd_scheduler #(
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             btn_req_i,
  input  logic [2:0]       btn_cmd_i,
  output logic             btn_ack_o,
  input  logic             clap_req_i,
  input  logic [2:0]       clap_cmd_i,
  output logic             clap_ack_o,
  output logic             rst_o,
  output logic             set_o,
  output logic [2:0]       state_o,
  output logic             busy_o,
  output logic             fifo_full_o,
  output logic             fifo_empty_o
`ifdef CMD_SCHEDULER_CMD_COUNT_EN
  ,
  output logic [CNT_W-1:0] cmd_cnt_o
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [2:0]    CMD_RST     = 3'b000;
  localparam logic [2:0]    CMD_SET     = 3'b111;
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    SETTLE
  } fsm_e;

  fsm_e          fsm_q;
  logic [SW-1:0] settle_q;

  logic [2:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;

  // High when the clap requester won the most recent grant.
  logic          last_clap_q;

  logic          fifo_full;
  logic          fifo_empty;
  logic          btn_elig;
  logic          clap_elig;
  logic          grant_btn;
  logic          grant_clap;
  logic          push;
  logic          pop;
  logic [2:0]    push_cmd;
  logic [2:0]    head_cmd;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign fifo_empty   = (wr_ptr_q == rd_ptr_q);
  assign fifo_full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign fifo_full_o  = fifo_full;
  assign fifo_empty_o = fifo_empty;
  assign head_cmd     = mem_q[rd_ptr_q[AW-1:0]];
  assign busy_o       = (fsm_q != IDLE);

  // Round-robin arbitration; a requester whose ack is high is masked.
  always_comb begin
    btn_elig   = btn_req_i  && !btn_ack_o  && !fifo_full;
    clap_elig  = clap_req_i && !clap_ack_o && !fifo_full;
    grant_btn  = btn_elig && (!clap_elig || last_clap_q);
    grant_clap = clap_elig && !grant_btn;
    push       = grant_btn || grant_clap;
    push_cmd   = grant_btn ? btn_cmd_i : clap_cmd_i;
    pop        = (fsm_q == IDLE) && !fifo_empty;
  end

  // FIFO storage write; contents are don't-care until pointed to.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_cmd;
    end
  end

  // FIFO pointers, registered acks and round-robin pointer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      btn_ack_o   <= 1'b0;
      clap_ack_o  <= 1'b0;
      last_clap_q <= 1'b1;
    end else begin
      btn_ack_o  <= grant_btn;
      clap_ack_o <= grant_clap;
      if (push) begin
        wr_ptr_q    <= wr_ptr_q + PW'(1);
        last_clap_q <= grant_clap;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
    end
  end

  // Issue FSM. The head entry is decoded on the pop edge so the registered
  // rst/set/state outputs are valid during the ISSUE cycle itself; this
  // removes the need for a separate command holding register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fsm_q    <= IDLE;
      settle_q <= '0;
      rst_o    <= 1'b0;
      set_o    <= 1'b0;
      state_o  <= '0;
    end else begin
      rst_o <= 1'b0;
      set_o <= 1'b0;
      unique case (fsm_q)
        IDLE: begin
          if (pop) begin
            fsm_q <= ISSUE;
            if (head_cmd == CMD_RST) begin
              rst_o <= 1'b1;
            end else if (head_cmd == CMD_SET) begin
              set_o <= 1'b1;
            end else begin
              state_o <= head_cmd;
            end
          end
        end
        ISSUE: begin
          fsm_q    <= SETTLE;
          settle_q <= SETTLE_LOAD;
        end
        SETTLE: begin
          if (settle_q == '0) begin
            fsm_q <= IDLE;
          end else begin
            settle_q <= settle_q - SW'(1);
          end
        end
        default: begin
          fsm_q <= IDLE;
        end
      endcase
    end
  end

`ifdef CMD_SCHEDULER_CMD_COUNT_EN
  // Issued-command counter; steps on the edge that enters ISSUE.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cmd_cnt_o <= '0;
    end else if (pop) begin
      cmd_cnt_o <= cmd_cnt_o + CNT_W'(1);
    end
  end
`else
  logic unused_cnt_w;
  assign unused_cnt_w = (CNT_W != 0);
`endif

endmodule
